ge_referee: RTL

- Sequential game master for the GE stage chain; drives the opposite side of each stage's interface.
- Per round, generates the random stage parameters (hard, luck) and presents the carried-in pass/bonus for the current stage.
- Collects each stage's pass/bonus result and advances through NUM_STAGES rounds.
- Reports game end, win or lose, and accumulated bonus.

---
 rtl/ge_referee.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ge_referee.sv
// Game master for the GE stage chain: issues per-round stage parameters from a
// Galois LFSR, collects each stage result and tracks win/lose and bonus total.
module ge_referee #(
    parameter int          NUM_STAGES = 4,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       round_valid,
    output logic [2:0] stage_idx,
    output logic [6:0] hard,
    output logic [1:0] luck,
    output logic       carry_pass,
    output logic [1:0] carry_bonus,
    input  logic       result_valid,
    input  logic       pass_in,
    input  logic [1:0] bonus_in,
    output logic       busy,
    output logic       game_done,
    output logic       game_win,
    output logic [4:0] total_bonus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_ISSUE,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_STAGES - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] lfsr;
    logic [7:0]  tmo_cnt;
    logic        res_pass;
    logic [1:0]  res_bonus;

    logic [15:0] lfsr_next;
    logic [6:0]  raw_hard;
    logic [6:0]  hard_next;
    logic [5:0]  bonus_sum;
    logic [4:0]  bonus_sat;

    // Next LFSR value and the stage parameters folded from it into legal ranges.
    always_comb begin
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
        raw_hard  = lfsr_next[6:0];
        hard_next = (raw_hard > 7'd100) ? (raw_hard - 7'd101) : raw_hard;
        bonus_sum = {1'b0, total_bonus} + {4'b0000, res_bonus};
        bonus_sat = bonus_sum[5] ? 5'd31 : bonus_sum[4:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lfsr        <= SEED;
            tmo_cnt     <= '0;
            res_pass    <= 1'b0;
            res_bonus   <= '0;
            round_valid <= 1'b0;
            stage_idx   <= '0;
            hard        <= '0;
            luck        <= '0;
            carry_pass  <= 1'b0;
            carry_bonus <= '0;
            busy        <= 1'b0;
            game_done   <= 1'b0;
            game_win    <= 1'b0;
            total_bonus <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        stage_idx   <= '0;
                        total_bonus <= '0;
                        game_win    <= 1'b0;
                        carry_pass  <= 1'b1;
                        carry_bonus <= '0;
                        busy        <= 1'b1;
                        state       <= S_GEN;
                    end
                end
                S_GEN: begin
                    lfsr        <= lfsr_next;
                    hard        <= hard_next;
                    luck        <= lfsr_next[8:7];
                    tmo_cnt     <= '0;
                    round_valid <= 1'b1;
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    // A real result arriving on the timeout edge takes priority.
                    if (result_valid) begin
                        res_pass    <= pass_in;
                        res_bonus   <= bonus_in;
                        round_valid <= 1'b0;
                        state       <= S_EVAL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_pass    <= 1'b0;
                        res_bonus   <= '0;
                        round_valid <= 1'b0;
                        state       <= S_EVAL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_EVAL: begin
                    if (!res_pass) begin
                        game_win  <= 1'b0;
                        game_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        total_bonus <= bonus_sat;
                        carry_bonus <= res_bonus;
                        if (stage_idx == LAST_IDX) begin
                            game_win  <= 1'b1;
                            game_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            stage_idx <= stage_idx + 3'd1;
                            state     <= S_GEN;
                        end
                    end
                end
                S_DONE: begin
                    game_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
